// File: rtl/ccc_lock_reset_ctrl_if.sv
// Lock/reset status bundle between the CCC lock consumer and the fabric that uses it.
// Latency: none, this file only groups wires.
// Backpressure: none, all signals are level or single-cycle pulse, no handshake.
//
// Ports carried:
//   lock_in   host -> ctrl   asynchronous CCC LOCK
//   clr_stat  host -> ctrl   single-cycle pulse clearing lock_err and loss_cnt
//   rst_out   ctrl -> host   active-high reset for CCC-clocked fabric
//   ready     ctrl -> host   high only while lock is qualified (RUN)
//   lock_err  ctrl -> host   sticky lock-timeout flag
//   loss_cnt  ctrl -> host   saturating count of lock losses seen in RUN
//   state     ctrl -> host   0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN
interface ccc_lock_reset_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             lock_in;
    logic             clr_stat;
    logic             rst_out;
    logic             ready;
    logic             lock_err;
    logic [CNT_W-1:0] loss_cnt;
    logic [1:0]       state;

    // Host / fabric side.
    modport master (
        output lock_in,
        output clr_stat,
        input  rst_out,
        input  ready,
        input  lock_err,
        input  loss_cnt,
        input  state
    );

    // Lock/reset controller side.
    modport slave (
        input  lock_in,
        input  clr_stat,
        output rst_out,
        output ready,
        output lock_err,
        output loss_cnt,
        output state
    );
endinterface

// File: rtl/ccc_lock_reset_ctrl.sv
// CCC lock consumer: synchronise/qualify LOCK, generate fabric reset, time out on lock, count losses.
// Latency: lock rise -> rst_out fall after SYNC_STAGES+LOCK_STABLE+RST_HOLD edges; loss -> rst_out rise after SYNC_STAGES.
// Backpressure: none; lock_in is free-running, clr_stat is a pulse, outputs are registered levels.
//
// Ports:
//   clk   free-running clock independent of the monitored CCC (RCOSC-derived)
//   rst   synchronous active-high reset
//   bus   slave modport of ccc_lock_reset_ctrl_if (lock_in, clr_stat in; rst_out, ready,
//         lock_err, loss_cnt, state out)
module ccc_lock_reset_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_STABLE  = 256,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ccc_lock_reset_ctrl_if.slave bus
);

    // One counter serves both STABLE and HOLD, so size it for the longer of the two.
    localparam int CNT_MAX  = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
    localparam int CNT_BITS = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMO_BITS = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(LOCK_STABLE - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST   = CNT_BITS'(RST_HOLD - 1);
    localparam logic [TMO_BITS-1:0] TMO_LAST    = TMO_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    LOSS_MAX    = '1;
    localparam logic [CNT_W-1:0]    LOSS_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [TMO_BITS-1:0]  tmo_q;
    logic                 rst_out_q;
    logic                 ready_q;
    logic                 lock_err_q;
    logic [CNT_W-1:0]     loss_cnt_q;

    // ------------------------------------------------------------------
    // LOCK synchroniser. lock_in comes from the CCC domain with no
    // relationship to clk; everything downstream looks only at lock_s.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.lock_in};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Events that feed the status registers. Both are evaluated against the
    // current state so they line up with the FSM edge that acts on them.
    logic loss_evt;
    logic tmo_evt;

    assign loss_evt = (state_q == RUN) && !lock_s;
    assign tmo_evt  = (state_q == WAIT_LOCK) && !lock_s && (tmo_q == TMO_LAST);

    // ------------------------------------------------------------------
    // Qualification FSM. rst_out/ready are written alongside every state
    // update so they always reflect the state being entered, i.e. they move
    // on the same edge as state without any decode glitches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            tmo_q     <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q   <= STABLE;
                        cnt_q     <= '0;
                        tmo_q     <= '0;
                        rst_out_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        // Timeout only flags an error; keep waiting with a fresh window.
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                STABLE: begin
                    if (!lock_s) begin
                        // Any drop restarts qualification from scratch.
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q   <= HOLD;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                HOLD: begin
                    if (!lock_s) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= WAIT_LOCK;
                    cnt_q     <= '0;
                    tmo_q     <= '0;
                    rst_out_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status. A clear coinciding with a new event keeps the event: the
    // timeout flag stays set, and the loss counter restarts at one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_err_q <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            if (tmo_evt) begin
                lock_err_q <= 1'b1;
            end else if (bus.clr_stat) begin
                lock_err_q <= 1'b0;
            end

            if (bus.clr_stat) begin
                loss_cnt_q <= loss_evt ? LOSS_ONE : '0;
            end else if (loss_evt && (loss_cnt_q != LOSS_MAX)) begin
                loss_cnt_q <= loss_cnt_q + 1'b1;
            end
        end
    end

    assign bus.rst_out  = rst_out_q;
    assign bus.ready    = ready_q;
    assign bus.lock_err = lock_err_q;
    assign bus.loss_cnt = loss_cnt_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_ctrl.sv
// Directed bench for ccc_lock_reset_ctrl with small qualification windows.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// A table of {lock, clr, ticks, expected outputs} records drives the main flow, then hand sequences.
module tb_ccc_lock_reset_ctrl;

    localparam int CNT_W = 8;
    localparam int NV    = 21;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ccc_lock_reset_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ccc_lock_reset_ctrl #(
        .SYNC_STAGES  (2),
        .LOCK_STABLE  (8),
        .RST_HOLD     (4),
        .LOCK_TIMEOUT (64),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic lock;
        logic clr;
        int   ticks;
        logic rst_out;
        logic ready;
        logic lock_err;
        int   loss;
        int   st;
    } vec_t;

    vec_t vecs [NV];

    int n_total = 0;
    int n_pass  = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int pack_out(input logic r, input logic rd, input logic e,
                                    input int loss, input int st);
        logic [12:0] p;
        p = {r, rd, e, 8'(loss), 2'(st)};
        return int'(p);
    endfunction

    initial begin
        // lock, clr, ticks, rst_out, ready, lock_err, loss, state
        vecs[0]  = '{1'b1, 1'b0, 2,  1'b1, 1'b0, 1'b0, 0, 0};  // edges 0,1: still syncing
        vecs[1]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 0, 1};  // edge 2: STABLE
        vecs[2]  = '{1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b0, 0, 2};  // edge 10: HOLD
        vecs[3]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 0, 2};  // edge 13: still held
        vecs[4]  = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 0, 3};  // edge 14: release
        vecs[5]  = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 0, 3};  // drop, edges 0,1
        vecs[6]  = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1, 0};  // edge 2: reset back, loss 1
        vecs[7]  = '{1'b1, 1'b0, 14, 1'b1, 1'b0, 1'b0, 1, 2};  // relock, edge 13
        vecs[8]  = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1, 3};  // edge 14
        vecs[9]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 0, 3};  // clr in RUN
        vecs[10] = '{1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1, 0};  // loss
        vecs[11] = '{1'b1, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1, 3};  // relock
        vecs[12] = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1, 3};  // drop, not yet seen
        vecs[13] = '{1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 1, 0};  // clr with loss -> 1
        vecs[14] = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1, 0};
        vecs[15] = '{1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1, 1};  // edges 0..4
        vecs[16] = '{1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1, 1};  // one-cycle glitch at edge 5
        vecs[17] = '{1'b1, 1'b0, 2,  1'b1, 1'b0, 1'b0, 1, 0};  // edge 7: glitch restarts
        vecs[18] = '{1'b1, 1'b0, 7,  1'b1, 1'b0, 1'b0, 1, 1};  // edge 14: no release
        vecs[19] = '{1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1, 2};  // 13 edges after re-rise
        vecs[20] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1, 3};  // 14 edges after re-rise

        rst          = 1'b1;
        bus.lock_in  = 1'b0;
        bus.clr_stat = 1'b0;
        tick(3);
        check("reset_outputs",
              pack_out(bus.rst_out, bus.ready, bus.lock_err, int'(bus.loss_cnt), int'(bus.state)),
              pack_out(1'b1, 1'b0, 1'b0, 0, 0));

        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            bus.lock_in  = vecs[i].lock;
            bus.clr_stat = vecs[i].clr;
            tick(vecs[i].ticks);
            check($sformatf("vec%0d", i),
                  pack_out(bus.rst_out, bus.ready, bus.lock_err, int'(bus.loss_cnt), int'(bus.state)),
                  pack_out(vecs[i].rst_out, vecs[i].ready, vecs[i].lock_err, vecs[i].loss, vecs[i].st));
        end
        bus.clr_stat = 1'b0;

        // Two more losses to reach loss_cnt=3, then reset from RUN.
        for (int i = 0; i < 2; i++) begin
            bus.lock_in = 1'b0;
            tick(3);
            bus.lock_in = 1'b1;
            tick(15);
        end
        check("loss_cnt_3", int'(bus.loss_cnt), 3);
        check("run_before_rst", int'(bus.state), 3);

        rst = 1'b1;
        tick(1);
        check("rst_in_run",
              pack_out(bus.rst_out, bus.ready, bus.lock_err, int'(bus.loss_cnt), int'(bus.state)),
              pack_out(1'b1, 1'b0, 1'b0, 0, 0));
        rst = 1'b0;
        tick(14);
        check("rst_requal_edge13", int'(bus.rst_out), 1);
        tick(1);
        check("rst_requal_edge14",
              pack_out(bus.rst_out, bus.ready, bus.lock_err, int'(bus.loss_cnt), int'(bus.state)),
              pack_out(1'b0, 1'b1, 1'b0, 0, 3));

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            bus.lock_in = 1'b0;
            tick(3);
            bus.lock_in = 1'b1;
            tick(15);
            if (i == 99) check("loss_cnt_100", int'(bus.loss_cnt), 100);
        end
        check("loss_cnt_sat", int'(bus.loss_cnt), 255);
        check("run_after_loop", int'(bus.state), 3);

        // Lock timeout: no lock after reset release.
        rst         = 1'b1;
        bus.lock_in = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(63);
        check("tmo_edge63", int'(bus.lock_err), 0);
        tick(1);
        check("tmo_edge64", int'(bus.lock_err), 1);
        tick(100);
        check("tmo_sticky", int'(bus.lock_err), 1);
        check("tmo_still_wait", int'(bus.state), 0);
        bus.lock_in = 1'b1;
        tick(15);
        check("late_lock_run", int'(bus.state), 3);
        check("late_lock_err_kept", int'(bus.lock_err), 1);
        bus.clr_stat = 1'b1;
        tick(1);
        bus.clr_stat = 1'b0;
        check("clr_lock_err", int'(bus.lock_err), 0);
        check("clr_keeps_run", int'(bus.ready), 1);

        // clr_stat on the timeout edge: the set wins.
        rst         = 1'b1;
        bus.lock_in = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(63);
        bus.clr_stat = 1'b1;
        tick(1);
        bus.clr_stat = 1'b0;
        check("clr_vs_tmo", int'(bus.lock_err), 1);
        tick(1);
        check("clr_vs_tmo_after", int'(bus.lock_err), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
